// File: rtl/gemm_tile_sequencer_if.sv
// GEMM tile sequencer datapath bundle: GLB fire/done, SA drain rows,
// ACC clear, data mover handshake and current tile indices.
interface gemm_tile_sequencer_if #(
    parameter int PE_SIZE = 14,
    parameter int T_W     = 16
);
    logic               glb_en_o;
    logic               glb_done_i;
    logic [PE_SIZE-1:0] psum_en_i;
    logic               acc_clr_o;
    logic               last_k_o;
    logic               mover_en_o;
    logic               mover_done_i;
    logic [T_W-1:0]     tile_k_o;
    logic [T_W-1:0]     tile_n_o;

    modport master (
        output glb_en_o, acc_clr_o, last_k_o, mover_en_o,
        output tile_k_o, tile_n_o,
        input  glb_done_i, psum_en_i, mover_done_i
    );

    modport slave (
        input  glb_en_o, acc_clr_o, last_k_o, mover_en_o,
        input  tile_k_o, tile_n_o,
        output glb_done_i, psum_en_i, mover_done_i
    );
endinterface

// File: rtl/gemm_tile_sequencer.sv
// Runtime-configured tile walker for GLB -> SA -> ACC -> mover.
// Optional busy/stall counters: define GEMM_SEQ_PERF_CNT_EN.
module gemm_tile_sequencer #(
    parameter int PE_SIZE    = 14,
    parameter int MAX_IN_CH  = 256,
    parameter int MAX_OUT_CH = 256,
    parameter int MAX_KERNEL = 7,
    parameter int CH_W = $clog2(MAX_IN_CH > MAX_OUT_CH ?
                                MAX_IN_CH : MAX_OUT_CH) + 1,
    parameter int KS_W = $clog2(MAX_KERNEL) + 1,
    parameter int K_W  = $clog2(MAX_IN_CH * MAX_KERNEL * MAX_KERNEL) + 1,
    parameter int T_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [CH_W-1:0] cfg_in_ch_i,
    input  logic [CH_W-1:0] cfg_out_ch_i,
    input  logic [KS_W-1:0] cfg_kernel_i,
    gemm_tile_sequencer_if.master sa,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [T_W-1:0]  perf_cycles_o,
    output logic [T_W-1:0]  perf_stall_o
);
    localparam int RC_W = $clog2(PE_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE, CFG, LOAD, STREAM, WRITE, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] in_ch_q, out_ch_q, n_base_q;
    logic [KS_W-1:0] ks_q;
    logic [K_W-1:0]  k_len_q, k_base_q, k_prod;
    logic [T_W-1:0]  tile_k_q, tile_n_q;
    logic [RC_W-1:0] row_cnt_q;
    logic            glb_seen_q, mv_sent_q, err_q;
    logic            cfg_bad, last_k, n_last, row_hit;
    logic            rows_full, glb_ok, stream_exit, abort_hit;
    logic            unused_psum;

    // Only the bottom row of the array marks a drained output row.
    assign unused_psum = ^sa.psum_en_i[PE_SIZE-2:0];
    assign row_hit     = sa.psum_en_i[PE_SIZE-1];

    assign k_prod  = K_W'(in_ch_q) * K_W'(ks_q) * K_W'(ks_q);
    assign cfg_bad = (in_ch_q == '0) || (in_ch_q > CH_W'(MAX_IN_CH)) ||
                     (out_ch_q == '0) || (out_ch_q > CH_W'(MAX_OUT_CH)) ||
                     (ks_q == '0) || (ks_q > KS_W'(MAX_KERNEL));

    // Tile bounds use compare/add on running bases instead of division.
    assign last_k = ({1'b0, k_base_q} + (K_W+1)'(PE_SIZE)) >=
                    {1'b0, k_len_q};
    assign n_last = ({1'b0, n_base_q} + (CH_W+1)'(PE_SIZE)) >=
                    {1'b0, out_ch_q};

    assign rows_full = (row_cnt_q == RC_W'(PE_SIZE)) ||
                       (row_hit && row_cnt_q == RC_W'(PE_SIZE - 1));
    assign glb_ok      = glb_seen_q || sa.glb_done_i;
    assign stream_exit = rows_full && glb_ok;
    assign abort_hit   = abort_i && (state_q != IDLE) && (state_q != DONE);

    // Next-state selection; abort overrides every working state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = CFG;
            CFG:     state_d = cfg_bad ? DONE : LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  if (stream_exit) state_d = last_k ? WRITE : LOAD;
            WRITE:   if (sa.mover_done_i) state_d = n_last ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = DONE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Job config, tile walk, row counting and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ch_q    <= '0;
            out_ch_q   <= '0;
            ks_q       <= '0;
            k_len_q    <= '0;
            k_base_q   <= '0;
            n_base_q   <= '0;
            tile_k_q   <= '0;
            tile_n_q   <= '0;
            row_cnt_q  <= '0;
            glb_seen_q <= 1'b0;
            mv_sent_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mv_sent_q <= (state_q == WRITE);
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        in_ch_q  <= cfg_in_ch_i;
                        out_ch_q <= cfg_out_ch_i;
                        ks_q     <= cfg_kernel_i;
                        err_q    <= 1'b0;
                    end
                end
                CFG: begin
                    k_len_q  <= k_prod;
                    k_base_q <= '0;
                    n_base_q <= '0;
                    tile_k_q <= '0;
                    tile_n_q <= '0;
                    if (cfg_bad && !abort_i) err_q <= 1'b1;
                end
                LOAD: begin
                    row_cnt_q  <= '0;
                    glb_seen_q <= 1'b0;
                end
                STREAM: begin
                    if (row_hit && row_cnt_q != RC_W'(PE_SIZE))
                        row_cnt_q <= row_cnt_q + RC_W'(1);
                    if (sa.glb_done_i) glb_seen_q <= 1'b1;
                    if (stream_exit && !last_k && !abort_i) begin
                        k_base_q <= k_base_q + K_W'(PE_SIZE);
                        tile_k_q <= tile_k_q + T_W'(1);
                    end
                end
                WRITE: begin
                    if (sa.mover_done_i && !n_last && !abort_i) begin
                        n_base_q <= n_base_q + CH_W'(PE_SIZE);
                        tile_n_q <= tile_n_q + T_W'(1);
                        tile_k_q <= '0;
                        k_base_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sa.glb_en_o   = (state_q == LOAD);
    assign sa.acc_clr_o  = (state_q == LOAD) && (tile_k_q == '0);
    assign sa.last_k_o   = ((state_q == LOAD) || (state_q == STREAM) ||
                            (state_q == WRITE)) && last_k;
    assign sa.mover_en_o = (state_q == WRITE) && !mv_sent_q;
    assign sa.tile_k_o   = tile_k_q;
    assign sa.tile_n_o   = tile_n_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign err_o         = err_q;

`ifdef GEMM_SEQ_PERF_CNT_EN
    logic [T_W-1:0] cyc_q, stall_q;

    // Saturating busy and mover-wait counters, cleared on accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != IDLE && cyc_q != '1)
                cyc_q <= cyc_q + T_W'(1);
            if (state_q == WRITE && !sa.mover_done_i && stall_q != '1)
                stall_q <= stall_q + T_W'(1);
        end
    end

    assign perf_cycles_o = cyc_q;
    assign perf_stall_o  = stall_q;
`else
    assign perf_cycles_o = '0;
    assign perf_stall_o  = '0;
`endif
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer: table jobs, random jobs against a
// tile-count model, plus abort, mid-job start and reset sequences.
`timescale 1ns/1ps
module tb_gemm_tile_sequencer;
    localparam int PE   = 14;
    localparam int T_W  = 16;
    localparam int CH_W = 9;
    localparam int KS_W = 4;

    typedef struct {
        int inc;
        int outc;
        int ks;
        bit err;
        int glb;
        int mv;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [CH_W-1:0] cfg_in_ch_i = '0;
    logic [CH_W-1:0] cfg_out_ch_i = '0;
    logic [KS_W-1:0] cfg_kernel_i = '0;
    logic            busy_o, done_o, err_o;
    logic [T_W-1:0]  perf_cycles_o, perf_stall_o;

    gemm_tile_sequencer_if #(.PE_SIZE(PE), .T_W(T_W)) sa ();

    gemm_tile_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .abort_i(abort_i),
        .cfg_in_ch_i(cfg_in_ch_i),
        .cfg_out_ch_i(cfg_out_ch_i),
        .cfg_kernel_i(cfg_kernel_i),
        .sa(sa),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .perf_cycles_o(perf_cycles_o),
        .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_kt = 0;
    int glb_cnt, clr_cnt, mv_cnt, done_cnt, busy_cnt, stall_sum;
    int t_first_glb, t_last_mvdone;
    int sa_mode = -1;
    int sa_delay = 1;
    int mv_force = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_mon(input int kt);
        exp_kt = kt;
        glb_cnt = 0; clr_cnt = 0; mv_cnt = 0; done_cnt = 0;
        busy_cnt = 0; stall_sum = 0;
        t_first_glb = -1; t_last_mvdone = -1;
    endtask

    // Model: the i-th GLB fire of a job is tile (i mod kt, i div kt).
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_o) busy_cnt++;
            if (sa.acc_clr_o) check("acc_clr_with_glb", sa.glb_en_o, 1);
            if (sa.glb_en_o) begin
                if (glb_cnt == 0) t_first_glb = cyc;
                if (exp_kt > 0) begin
                    check("tile_k", sa.tile_k_o, glb_cnt % exp_kt);
                    check("tile_n", sa.tile_n_o, glb_cnt / exp_kt);
                    check("acc_clr", sa.acc_clr_o, (glb_cnt % exp_kt) == 0);
                    check("last_k", sa.last_k_o,
                          (glb_cnt % exp_kt) == exp_kt - 1);
                end
                glb_cnt++;
                if (sa.acc_clr_o) clr_cnt++;
            end
            if (sa.mover_en_o) begin
                check("mover_tile_n", sa.tile_n_o, mv_cnt);
                mv_cnt++;
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic stream_tile();
        int rows, mode, wait_left;
        bit gd_sent, gd, hit;
        logic [PE-1:0] pe;
        rows = 0;
        gd_sent = 0;
        mode = (sa_mode >= 0) ? sa_mode : int'($urandom_range(0, 2));
        wait_left = (sa_mode >= 0) ? sa_delay : int'($urandom_range(1, 4));
        while (!(rows == PE && gd_sent)) begin
            @(negedge clk);
            if (!rst_n || !busy_o) break;
            pe = PE'($urandom);
            pe[PE-1] = 1'b0;
            gd = 0;
            hit = 0;
            if (rows < PE && $urandom_range(0, 3) != 0) begin
                pe[PE-1] = 1'b1;
                rows++;
                hit = 1;
            end
            if (!gd_sent) begin
                case (mode)
                    0: gd = hit && rows == PE;
                    1: if (rows == PE && !hit) begin
                        wait_left--;
                        gd = (wait_left == 0);
                    end
                    default: gd = (rows >= 1);
                endcase
            end
            sa.psum_en_i = pe;
            sa.glb_done_i = gd;
            if (gd) gd_sent = 1;
        end
    endtask

    // Systolic array stand-in: streams 14 rows per GLB fire.
    initial begin
        sa.glb_done_i = 1'b0;
        sa.psum_en_i = '0;
        forever begin
            @(negedge clk);
            sa.glb_done_i = 1'b0;
            sa.psum_en_i = '0;
            if (rst_n && sa.glb_en_o) stream_tile();
        end
    end

    // Data mover stand-in: completes after a random delay.
    initial begin
        int d;
        sa.mover_done_i = 1'b0;
        forever begin
            @(negedge clk);
            sa.mover_done_i = 1'b0;
            if (rst_n && sa.mover_en_o) begin
                d = (mv_force >= 0) ? mv_force : int'($urandom_range(0, 4));
                stall_sum += d;
                repeat (d) @(negedge clk);
                sa.mover_done_i = 1'b1;
                t_last_mvdone = cyc;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, " glb_en"}, sa.glb_en_o, 0);
        check({tag, " acc_clr"}, sa.acc_clr_o, 0);
        check({tag, " last_k"}, sa.last_k_o, 0);
        check({tag, " mover_en"}, sa.mover_en_o, 0);
        check({tag, " tile_k"}, sa.tile_k_o, 0);
        check({tag, " tile_n"}, sa.tile_n_o, 0);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " done"}, done_o, 0);
        check({tag, " err"}, err_o, 0);
        check({tag, " perf_cycles"}, perf_cycles_o, 0);
        check({tag, " perf_stall"}, perf_stall_o, 0);
    endtask

    task automatic run_job(input int inc, input int outc, input int ks,
                           input bit exp_err, input int exp_glb,
                           input int exp_mv, input bit poke,
                           input string tag);
        int kt, t_start, t_done;
        bit seen;
        kt = exp_err ? 0 : (inc * ks * ks + PE - 1) / PE;
        reset_mon(kt);
        seen = 0;
        t_done = -1;
        @(negedge clk);
        cfg_in_ch_i = CH_W'(inc);
        cfg_out_ch_i = CH_W'(outc);
        cfg_kernel_i = KS_W'(ks);
        start_i = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, " err_clr_on_start"}, err_o, 0);
        check({tag, " busy_after_start"}, busy_o, 1);
        for (int i = 0; i < 20000; i++) begin
            if (done_o) begin
                seen = 1;
                t_done = cyc;
                break;
            end
            if (poke) begin
                start_i = 1'($urandom_range(0, 1));
                cfg_in_ch_i = CH_W'($urandom);
                cfg_out_ch_i = CH_W'($urandom);
                cfg_kernel_i = KS_W'($urandom);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        if (seen) begin
            check({tag, " err_at_done"}, err_o, exp_err);
            if (exp_err) begin
                check({tag, " err_done_lat"}, t_done - t_start, 2);
            end else begin
                check({tag, " first_glb_lat"}, t_first_glb - t_start, 2);
                check({tag, " mvdone_to_done"}, t_done - t_last_mvdone, 1);
            end
        end
        @(negedge clk);
        check({tag, " busy_clear"}, busy_o, 0);
        check({tag, " done_pulse"}, done_o, 0);
        check({tag, " err_sticky"}, err_o, exp_err);
        check({tag, " glb_count"}, glb_cnt, exp_glb);
        check({tag, " clr_count"}, clr_cnt, exp_mv);
        check({tag, " mover_count"}, mv_cnt, exp_mv);
        check({tag, " done_count"}, done_cnt, 1);
`ifdef GEMM_SEQ_PERF_CNT_EN
        check({tag, " perf_cycles"}, perf_cycles_o, busy_cnt);
        check({tag, " perf_stall"}, perf_stall_o, stall_sum);
`else
        check({tag, " perf_cycles_off"}, perf_cycles_o, 0);
        check({tag, " perf_stall_off"}, perf_stall_o, 0);
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        int inc, outc, ks, kt, nt;
        bit bad, seen;

        vt[0]  = '{32, 64, 3, 1'b0, 105, 5};
        vt[1]  = '{1, 1, 1, 1'b0, 1, 1};
        vt[2]  = '{32, 0, 3, 1'b1, 0, 0};
        vt[3]  = '{14, 14, 1, 1'b0, 1, 1};
        vt[4]  = '{15, 15, 1, 1'b0, 4, 2};
        vt[5]  = '{5, 28, 2, 1'b0, 4, 2};
        vt[6]  = '{257, 14, 1, 1'b1, 0, 0};
        vt[7]  = '{14, 257, 1, 1'b1, 0, 0};
        vt[8]  = '{14, 14, 8, 1'b1, 0, 0};
        vt[9]  = '{0, 14, 1, 1'b1, 0, 0};
        vt[10] = '{14, 14, 0, 1'b1, 0, 0};
        vt[11] = '{256, 14, 1, 1'b0, 19, 1};
        vt[12] = '{1, 256, 1, 1'b0, 19, 19};
        vt[13] = '{2, 15, 7, 1'b0, 14, 2};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_job(vt[i].inc, vt[i].outc, vt[i].ks, vt[i].err,
                    vt[i].glb, vt[i].mv, 1'b0, $sformatf("vec%0d", i));

        sa_mode = 0;
        run_job(14, 14, 1, 1'b0, 1, 1, 1'b0, "glb_coincident");
        sa_mode = 1;
        sa_delay = 5;
        run_job(14, 14, 1, 1'b0, 1, 1, 1'b0, "glb_late5");
        sa_mode = 2;
        run_job(28, 14, 1, 1'b0, 2, 1, 1'b0, "glb_early");
        sa_mode = -1;

        run_job(28, 28, 1, 1'b0, 4, 2, 1'b1, "start_midjob");

        for (int j = 0; j < 10; j++) begin
            inc = $urandom_range(1, 40);
            outc = $urandom_range(1, 40);
            ks = $urandom_range(1, 3);
            bad = ($urandom_range(0, 7) == 0);
            if (bad) outc = 0;
            kt = (inc * ks * ks + PE - 1) / PE;
            nt = (outc + PE - 1) / PE;
            run_job(inc, outc, ks, bad, bad ? 0 : kt * nt, bad ? 0 : nt,
                    1'b0, $sformatf("rand%0d", j));
        end

        reset_mon(2);
        @(negedge clk);
        cfg_in_ch_i = CH_W'(28);
        cfg_out_ch_i = CH_W'(28);
        cfg_kernel_i = KS_W'(1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = sa.glb_en_o;
        end
        check("abort glb_seen", seen, 1);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort done_next", done_o, 1);
        check("abort err_kept", err_o, 0);
        @(negedge clk);
        check("abort busy_clear", busy_o, 0);
        check("abort glb_count", glb_cnt, 1);
        repeat (10) @(negedge clk);

        reset_mon(2);
        mv_force = 8;
        @(negedge clk);
        cfg_in_ch_i = CH_W'(15);
        cfg_out_ch_i = CH_W'(28);
        cfg_kernel_i = KS_W'(1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 400 && mv_cnt < 2; i++) @(negedge clk);
        check("rstw mover_count", mv_cnt, 2);
        repeat (3) @(negedge clk);
        check("rstw tile_n", sa.tile_n_o, 1);
`ifdef GEMM_SEQ_PERF_CNT_EN
        check("rstw perf_stall", perf_stall_o, 11);
`endif
        #2 rst_n = 1'b0;
        #1 check_zero("rstw");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstw no_done", done_cnt, 0);
        check("rstw idle", busy_o, 0);
        mv_force = -1;

        run_job(1, 1, 1, 1'b0, 1, 1, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
